// File: rtl/cam_capture_writer.sv
// Camera byte stream to frame-buffer writer: pairs bytes into RGB444 pixels,
// optionally decimates 2:1 in both directions and emits capped write addresses.
module cam_capture_writer #(
    parameter int H_IN         = 640,
    parameter int DECIMATE     = 1,
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17
) (
    input  logic              CLK25,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              byte_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);
    localparam int COL_W  = $clog2(H_IN);
    localparam int LINE_W = 9;
    localparam logic [ADDR_W-1:0] ADDR_CAP = ADDR_W'(FRAME_PIXELS);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        CAPTURE   = 1'b1
    } state_t;

    state_t             state;
    logic               vsync_d;
    logic               href_d;
    logic               phase;
    logic [3:0]         red;
    logic [COL_W-1:0]   col_cnt;
    logic [LINE_W-1:0]  line_cnt;

    logic vsync_fall;
    logic vsync_rise;
    logic href_fall;
    logic byte_acc;
    logic keep;

    always_comb begin
        vsync_fall = vsync_d & ~cam_vsync;
        vsync_rise = ~vsync_d & cam_vsync;
        href_fall  = href_d & ~cam_href;
        byte_acc   = byte_valid & cam_href;
        keep       = (DECIMATE == 0) || (!col_cnt[0] && !line_cnt[0]);
    end

    always_ff @(posedge CLK25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_SYNC;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            phase      <= 1'b0;
            red        <= 4'd0;
            col_cnt    <= '0;
            line_cnt   <= '0;
            wr_addr    <= '0;
            wr_data    <= 12'd0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            // Address advances the cycle after each write; a write only
            // happens below ADDR_CAP, so this never passes the cap.
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end

            if (vsync_fall) begin
                state    <= CAPTURE;
                busy     <= 1'b1;
                wr_addr  <= '0;
                col_cnt  <= '0;
                line_cnt <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (state == CAPTURE) begin
                if (vsync_rise) begin
                    state      <= WAIT_SYNC;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end else if (href_fall) begin
                    // An odd trailing byte is discarded with the line.
                    phase   <= 1'b0;
                    col_cnt <= '0;
                    if (col_cnt != '0 && !(&line_cnt)) begin
                        line_cnt <= line_cnt + LINE_W'(1);
                    end
                end else if (byte_acc) begin
                    if (!phase) begin
                        red   <= cam_data[3:0];
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!(&col_cnt)) begin
                            col_cnt <= col_cnt + COL_W'(1);
                        end
                        if (keep) begin
                            if (wr_addr < ADDR_CAP) begin
                                wr_en   <= 1'b1;
                                wr_data <= {red, cam_data};
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_writer.sv
// Directed bench: one decimating and one pass-through instance share the
// camera stimulus; both use a 6-location frame buffer so the cap is reachable.
module tb_cam_capture_writer;
    localparam int ADDR_W = 17;
    localparam int FP     = 6;

    logic              CLK25 = 1'b0;
    logic              rst_n;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              byte_valid;

    logic [ADDR_W-1:0] wr_addr_d, wr_addr_a;
    logic [11:0]       wr_data_d, wr_data_a;
    logic              wr_en_d, wr_en_a;
    logic              frame_done_d, frame_done_a;
    logic              overflow_d, overflow_a;
    logic              busy_d, busy_a;

    int n_checks = 0;
    int n_fail   = 0;
    int done_d   = 0;
    int done_a   = 0;

    logic [ADDR_W+11:0] exp_dec_q[$];
    logic [ADDR_W+11:0] exp_all_q[$];
    logic [ADDR_W+11:0] got_dec_q[$];
    logic [ADDR_W+11:0] got_all_q[$];

    always #20 CLK25 = ~CLK25;

    cam_capture_writer #(.H_IN(640), .DECIMATE(1), .FRAME_PIXELS(FP), .ADDR_W(ADDR_W)) u_dec (
        .CLK25(CLK25), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .byte_valid(byte_valid), .wr_addr(wr_addr_d),
        .wr_data(wr_data_d), .wr_en(wr_en_d), .frame_done(frame_done_d),
        .overflow(overflow_d), .busy(busy_d)
    );

    cam_capture_writer #(.H_IN(640), .DECIMATE(0), .FRAME_PIXELS(FP), .ADDR_W(ADDR_W)) u_all (
        .CLK25(CLK25), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .byte_valid(byte_valid), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_en(wr_en_a), .frame_done(frame_done_a),
        .overflow(overflow_a), .busy(busy_a)
    );

    // Record every write and frame_done pulse seen mid-cycle.
    always @(negedge CLK25) begin
        if (wr_en_d) got_dec_q.push_back({wr_addr_d, wr_data_d});
        if (wr_en_a) got_all_q.push_back({wr_addr_a, wr_data_a});
        if (frame_done_d) done_d++;
        if (frame_done_a) done_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK25);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data   = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic line_end();
        cam_href = 1'b0;
        tick();
    endtask

    task automatic frame_start();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
    endtask

    // Expected write (or its absence) on one instance; expected writes join the scoreboard.
    task automatic chk_wr(input string tag, input bit dec, input logic exp_en,
                          input logic [11:0] exp_data, input logic [ADDR_W-1:0] exp_addr);
        logic              en;
        logic [11:0]       d;
        logic [ADDR_W-1:0] a;
        en = dec ? wr_en_d   : wr_en_a;
        d  = dec ? wr_data_d : wr_data_a;
        a  = dec ? wr_addr_d : wr_addr_a;
        check({tag, "_en"}, 32'(en), 32'(exp_en));
        if (exp_en) begin
            check({tag, "_data"}, 32'(d), 32'(exp_data));
            check({tag, "_addr"}, 32'(a), 32'(exp_addr));
            if (dec) exp_dec_q.push_back({exp_addr, exp_data});
            else     exp_all_q.push_back({exp_addr, exp_data});
        end
    endtask

    task automatic chk_state(input string tag, input bit dec, input logic exp_busy,
                             input logic exp_ovf, input logic exp_fd,
                             input logic [ADDR_W-1:0] exp_addr);
        check({tag, "_busy"}, 32'(dec ? busy_d : busy_a), 32'(exp_busy));
        check({tag, "_ovf"},  32'(dec ? overflow_d : overflow_a), 32'(exp_ovf));
        check({tag, "_fdone"}, 32'(dec ? frame_done_d : frame_done_a), 32'(exp_fd));
        check({tag, "_addr"}, 32'(dec ? wr_addr_d : wr_addr_a), 32'(exp_addr));
    endtask

    initial begin
        rst_n      = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b1;
        byte_valid = 1'b0;
        cam_data   = 8'h00;
        tick();
        tick();
        chk_state("rst_d", 1, 0, 0, 0, 0);
        chk_state("rst_a", 0, 0, 0, 0, 0);
        check("rst_wren_d", 32'(wr_en_d), 32'd0);
        check("rst_wdata_d", 32'(wr_data_d), 32'd0);
        check("rst_wren_a", 32'(wr_en_a), 32'd0);

        // Release in the middle of an active line: nothing is captured.
        rst_n = 1'b1;
        send_pixel(8'h0A, 8'hBC);
        send_pixel(8'h01, 8'h23);
        tick();
        check("mid_writes_d", 32'(got_dec_q.size()), 32'd0);
        check("mid_writes_a", 32'(got_all_q.size()), 32'd0);
        chk_state("mid_d", 1, 0, 0, 0, 0);
        line_end();

        // Frame 1
        frame_start();
        chk_state("f1_start_d", 1, 1, 0, 0, 0);
        chk_state("f1_start_a", 0, 1, 0, 0, 0);

        cam_href = 1'b1;                              // line 0
        send_pixel(8'h0A, 8'hBC);
        chk_wr("l0p0_d", 1, 1, 12'hABC, 0);
        chk_wr("l0p0_a", 0, 1, 12'hABC, 0);
        send_pixel(8'hF5, 8'h3C);
        chk_wr("l0p1_d", 1, 0, 12'h000, 0);
        chk_wr("l0p1_a", 0, 1, 12'h53C, 1);
        send_pixel(8'h01, 8'h23);
        chk_wr("l0p2_d", 1, 1, 12'h123, 1);
        chk_wr("l0p2_a", 0, 1, 12'h123, 2);
        send_pixel(8'h04, 8'h56);
        chk_wr("l0p3_d", 1, 0, 12'h000, 0);
        chk_wr("l0p3_a", 0, 1, 12'h456, 3);
        send_byte(8'h0F);                             // odd trailing byte
        line_end();
        chk_state("l0_end_d", 1, 1, 0, 0, 2);
        chk_state("l0_end_a", 0, 1, 0, 0, 4);
        send_byte(8'hAA);                             // href low: ignored

        cam_href = 1'b1;                              // line 1
        send_pixel(8'h58, 8'h9A);
        chk_wr("l1p0_d", 1, 0, 12'h000, 0);
        chk_wr("l1p0_a", 0, 1, 12'h89A, 4);
        send_pixel(8'h0B, 8'hCD);
        chk_wr("l1p1_a", 0, 1, 12'hBCD, 5);
        send_pixel(8'h0C, 8'hDE);
        chk_wr("l1p2_a", 0, 0, 12'h000, 0);
        chk_state("l1_cap_a", 0, 1, 1, 0, 6);
        chk_state("l1_cap_d", 1, 1, 0, 0, 2);
        send_pixel(8'h0D, 8'hEF);
        chk_wr("l1p3_a", 0, 0, 12'h000, 0);
        line_end();

        cam_href = 1'b1;                              // line 2: three bytes
        send_pixel(8'h0E, 8'h77);
        chk_wr("l2p0_d", 1, 1, 12'hE77, 2);
        chk_wr("l2p0_a", 0, 0, 12'h000, 0);
        send_byte(8'h99);
        line_end();

        cam_href = 1'b1;                              // empty href pulse
        tick();
        tick();
        line_end();

        cam_href = 1'b1;                              // line 3
        send_pixel(8'h01, 8'h11);
        chk_wr("l3p0_d", 1, 0, 12'h000, 0);
        line_end();

        cam_href = 1'b1;                              // line 4
        send_pixel(8'h02, 8'h34);
        chk_wr("l4p0_d", 1, 1, 12'h234, 3);
        send_pixel(8'h03, 8'h45);
        chk_wr("l4p1_d", 1, 0, 12'h000, 0);
        send_byte(8'h05);
        cam_vsync = 1'b1;                             // rise together with a kept byte
        send_byte(8'h67);
        chk_wr("rise_byte_d", 1, 0, 12'h000, 0);
        chk_state("f1_end_d", 1, 0, 0, 1, 4);
        chk_state("f1_end_a", 0, 0, 1, 1, 6);
        tick();
        check("f1_fd_pulse_d", 32'(frame_done_d), 32'd0);
        line_end();

        cam_href = 1'b1;                              // bytes during blanking
        send_pixel(8'h0A, 8'hBC);
        chk_wr("blank_d", 1, 0, 12'h000, 0);
        chk_wr("blank_a", 0, 0, 12'h000, 0);
        line_end();
        chk_state("blank_a", 0, 0, 1, 0, 6);

        // Frame 2, interrupted by reset
        cam_vsync = 1'b0;
        tick();
        chk_state("f2_start_d", 1, 1, 0, 0, 0);
        chk_state("f2_start_a", 0, 1, 0, 0, 0);
        cam_href = 1'b1;
        send_pixel(8'h0F, 8'hFF);
        chk_wr("f2p0_d", 1, 1, 12'hFFF, 0);
        chk_wr("f2p0_a", 0, 1, 12'hFFF, 0);
        send_pixel(8'h01, 8'h22);
        check("f2p1_en_a", 32'(wr_en_a), 32'd1);
        check("f2p1_data_a", 32'(wr_data_a), 32'h122);
        #5;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst_d", 1, 0, 0, 0, 0);
        chk_state("async_rst_a", 0, 0, 0, 0, 0);
        check("async_rst_en_a", 32'(wr_en_a), 32'd0);
        check("async_rst_data_a", 32'(wr_data_a), 32'd0);
        tick();
        rst_n = 1'b1;
        send_pixel(8'h0A, 8'hBC);
        chk_wr("post_rst_d", 1, 0, 12'h000, 0);
        chk_wr("post_rst_a", 0, 0, 12'h000, 0);

        // Frame 3
        frame_start();
        chk_state("f3_start_d", 1, 1, 0, 0, 0);
        cam_href = 1'b1;
        send_pixel(8'h03, 8'h21);
        chk_wr("f3p0_d", 1, 1, 12'h321, 0);
        chk_wr("f3p0_a", 0, 1, 12'h321, 0);
        line_end();
        cam_vsync = 1'b1;
        tick();
        check("f3_fd_d", 32'(frame_done_d), 32'd1);
        check("f3_fd_a", 32'(frame_done_a), 32'd1);
        tick();
        tick();

        check("fd_count_d", 32'(done_d), 32'd2);
        check("fd_count_a", 32'(done_a), 32'd2);
        check("writes_d", 32'(got_dec_q.size()), 32'(exp_dec_q.size()));
        check("writes_a", 32'(got_all_q.size()), 32'(exp_all_q.size()));
        for (int i = 0; i < exp_dec_q.size(); i++) begin
            check($sformatf("sb_d%0d", i),
                  (i < got_dec_q.size()) ? 32'(got_dec_q[i]) : 32'hFFFF_FFFF, 32'(exp_dec_q[i]));
        end
        for (int i = 0; i < exp_all_q.size(); i++) begin
            check($sformatf("sb_a%0d", i),
                  (i < got_all_q.size()) ? 32'(got_all_q[i]) : 32'hFFFF_FFFF, 32'(exp_all_q[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_capture_writer.md
Name: cam_capture_writer

Overview:
- Write side of the 320x240 frame buffer; pairs with the VGA-side read address generator.
- Accepts camera byte stream (vsync/href/8-bit data with byte strobe) synchronous to CLK25.
- Assembles byte pairs into 12-bit RGB444 pixels and applies optional 2:1 horizontal and vertical decimation (640x480 -> 320x240).
- Emits frame-buffer write address, data and write enable, plus frame status.

Parameters:
- H_IN, 640, active input pixels per line (used for decimation column count).
- DECIMATE, 1, 1 = keep even columns of even lines only; 0 = keep every pixel.
- FRAME_PIXELS, 76800, number of frame-buffer locations; write address limit.
- ADDR_W, 17, write address width.

Ports:
- CLK25  input  1  25 MHz system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cam_vsync  input  1  camera vertical sync, high during inter-frame blanking.
- cam_href  input  1  camera line valid, high during active bytes.
- cam_data  input  8  camera byte.
- byte_valid  input  1  one-cycle strobe qualifying cam_data/cam_href.
- wr_addr  output  ADDR_W  frame-buffer write address.
- wr_data  output  12  pixel {R[3:0],G[3:0],B[3:0]}.
- wr_en  output  1  one-cycle write strobe.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- overflow  output  1  sticky; frame delivered more than FRAME_PIXELS kept pixels.
- busy  output  1  high while in CAPTURE state.

Behaviour:
- Reset (async, rst_n=0): wr_addr=0, wr_data=0, wr_en=0, frame_done=0, overflow=0, busy=0, state=WAIT_SYNC, byte phase=0, column/line counters=0, vsync_d=0.
- Edge detection: vsync_d registers cam_vsync every cycle. fall = vsync_d & ~cam_vsync; rise = ~vsync_d & cam_vsync.
- States:
  - WAIT_SYNC: ignore all bytes. On fall: go to CAPTURE; clear wr_addr, counters, phase and overflow.
  - CAPTURE: accept bytes. On rise: pulse frame_done next cycle, go to WAIT_SYNC. On fall (missed rise): restart exactly as from WAIT_SYNC, with no frame_done.
- Mid-frame start: power-up or reset while the camera is mid-frame discards everything until the first fall.
- Byte accept: in CAPTURE, a byte is accepted when byte_valid=1 and cam_href=1. Bytes with cam_href=0 are ignored, even if byte_valid=1.
- Byte phase 0: latch cam_data[3:0] as R; phase toggles to 1.
- Byte phase 1: form pixel {R, cam_data[7:0]}; increment column counter; phase returns to 0.
- href falling edge (registered href_d=1, cam_href=0):
  - phase forced to 0, so an odd trailing byte is dropped;
  - column counter cleared;
  - line counter increments if the column counter was nonzero.
- Keep rule: DECIMATE=1 keeps a pixel only if column[0]=0 and line[0]=0. DECIMATE=0 keeps all pixels.
- Write (kept pixel):
  - if wr_addr < FRAME_PIXELS: in the cycle after the phase-1 byte, wr_en=1 and wr_data=pixel, with wr_addr holding the address being written;
  - wr_addr increments one cycle after the wr_en cycle.
  - Latency is 1 cycle, byte strobe to wr_en.
  - Maximum rate: one write per two byte strobes.
- Address cap: a kept pixel with wr_addr = FRAME_PIXELS is dropped (no wr_en) and sets overflow=1. wr_addr never exceeds FRAME_PIXELS.
- Overflow clearing: overflow clears only on the next frame-start fall.
- Simultaneous rise and accepted byte: rise wins; the byte is ignored.
- Counters: column is 10 bits, line is 9 bits, both saturating. They only influence decimation, so no wrap effects.
- busy=1 exactly while state=CAPTURE (registered).

Test Plan:
- Full frame, DECIMATE=1: vsync fall, 480 lines x 1280 bytes, then vsync rise -> 76800 wr_en pulses; addresses 0..76799 in order; frame_done one cycle after rise; overflow=0.
- Pixel packing: bytes 0x0A then 0xBC in an active line -> wr_en one cycle after the 0xBC strobe, wr_data=0xABC at addr 0. Bytes 0xF5,0x3C -> 0x53C.
- Decimation: DECIMATE=1, first line of 4 pixels P0..P3 -> only P0,P2 written (addr 0,1). Second line -> no writes. Third line -> next writes at addr 2.
- Overflow: DECIMATE=0, 76802 pixels -> 76800 writes, wr_addr stops at 76800, overflow=1. Overflow stays 1 until the next vsync fall, then returns to 0 with wr_addr=0.
- Mid-frame start and odd byte: release reset with href already active -> no writes until a vsync fall. A line ending after 3 bytes -> one write; next line's first byte is treated as phase 0.
- Reset mid-capture: assert rst_n=0 asynchronously during a line -> all outputs 0 immediately, busy=0. After release, writes resume only after the next vsync fall, starting at addr 0.
